// File: rtl/ann_weight_pkg.sv
// Shared definitions for the ANN weight path: default geometry, sequencer
// states and the weight word type used by the loader, sequencer and MAC.
package ann_weight_pkg;

  localparam int unsigned DEPTH_DEF  = 28;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  typedef logic [DATA_W_DEF-1:0] weight_word_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding BRAM read data plus its last flag; slot 0 is the
// registered head presented to the consumer.
module weight_skid_fifo #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);

  logic              vld0_q, vld0_d, vld1_q, vld1_d;
  logic              lst0_q, lst0_d, lst1_q, lst1_d;
  logic [DATA_W-1:0] dat0_q, dat0_d, dat1_q, dat1_d;

  always_comb begin
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    lst0_d = lst0_q;
    lst1_d = lst1_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
    if (pop) begin
      if (vld1_q) begin
        dat0_d = dat1_q;
        lst0_d = lst1_q;
        vld1_d = push;
        if (push) begin
          dat1_d = push_data;
          lst1_d = push_last;
        end
      end else if (push) begin
        dat0_d = push_data;
        lst0_d = push_last;
      end else begin
        // keep data, but drop last so it never shows without valid
        vld0_d = 1'b0;
        lst0_d = 1'b0;
      end
    end else if (push) begin
      if (!vld0_q) begin
        vld0_d = 1'b1;
        dat0_d = push_data;
        lst0_d = push_last;
      end else begin
        vld1_d = 1'b1;
        dat1_d = push_data;
        lst1_d = push_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      lst0_q <= 1'b0;
      lst1_q <= 1'b0;
      dat0_q <= '0;
      dat1_q <= '0;
    end else begin
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
      lst0_q <= lst0_d;
      lst1_q <= lst1_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
    end
  end

  assign head_valid = vld0_q;
  assign head_data  = dat0_q;
  assign head_last  = lst0_q;
  assign count      = {vld1_q, vld0_q ^ vld1_q};

endmodule

// File: rtl/weight_bram_sequencer.sv
// Owns the single-port weight BRAM for one neuron: fills it from the loader
// and streams it in address order to the MAC through a 2-entry buffer.
module weight_bram_sequencer
  import ann_weight_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              start,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              w_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_di,
  output logic              bram_en,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_do
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  seq_state_t        st_q, st_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_di_q, bram_di_d;
  logic              bram_en_q, bram_en_d, bram_we_q, bram_we_d;
  logic              load_ready_q, load_ready_d, load_done_q, load_done_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              inflight_q, inflight_d, inflight_last_q, inflight_last_d;

  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              rd_issue;

  weight_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push       (inflight_q),
    .push_data  (bram_do),
    .push_last  (inflight_last_q),
    .pop        (fifo_pop),
    .head_valid (w_valid),
    .head_data  (w_data),
    .head_last  (w_last),
    .count      (fifo_count)
  );

  assign fifo_pop  = w_valid & w_ready;
  // words buffered or on their way, after this cycle's pop
  assign occupancy = 3'({1'b0, fifo_count}) + 3'(inflight_q) - 3'(fifo_pop);

  always_comb begin
    st_d            = st_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    bram_addr_d     = bram_addr_q;
    bram_di_d       = bram_di_q;
    bram_en_d       = 1'b0;
    bram_we_d       = 1'b0;
    load_done_d     = 1'b0;
    done_d          = 1'b0;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    rd_issue        = 1'b0;

    case (st_q)
      IDLE: begin
        if (load_start) begin
          st_d = LOAD;
        end else if (start) begin
          rd_issue = 1'b1;
        end
      end
      LOAD: begin
        if (load_valid && load_ready_q) begin
          bram_addr_d = wr_ptr_q;
          bram_di_d   = load_data;
          bram_en_d   = 1'b1;
          bram_we_d   = 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d    = '0;
            st_d        = IDLE;
            load_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      READ: begin
        rd_issue = (occupancy < 3'd2);
      end
      DRAIN: begin
        if (fifo_pop && w_last) begin
          st_d   = IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase

    // read issue is shared by the IDLE launch and READ streaming
    if (rd_issue) begin
      bram_addr_d     = rd_ptr_q;
      bram_en_d       = 1'b1;
      inflight_d      = 1'b1;
      inflight_last_d = (rd_ptr_q == LAST_ADDR);
      if (rd_ptr_q == LAST_ADDR) begin
        rd_ptr_d = '0;
        st_d     = DRAIN;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        st_d     = READ;
      end
    end

    load_ready_d = (st_d == LOAD);
    busy_d       = (st_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q            <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      bram_addr_q     <= '0;
      bram_di_q       <= '0;
      bram_en_q       <= 1'b0;
      bram_we_q       <= 1'b0;
      load_ready_q    <= 1'b0;
      load_done_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      st_q            <= st_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      bram_addr_q     <= bram_addr_d;
      bram_di_q       <= bram_di_d;
      bram_en_q       <= bram_en_d;
      bram_we_q       <= bram_we_d;
      load_ready_q    <= load_ready_d;
      load_done_q     <= load_done_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign bram_addr  = bram_addr_q;
  assign bram_di    = bram_di_q;
  assign bram_en    = bram_en_q;
  assign bram_we    = bram_we_q;
  assign load_ready = load_ready_q;
  assign load_done  = load_done_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
